// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic PORT_IF     = 1'b0;
    localparam logic PORT_DM     = 1'b1;
    localparam int   MEM_LAT_MAX = 15;
    localparam int   CNT_W       = 4;

    // A lone requester always wins; tie_gnt settles simultaneous requests.
    function automatic logic arb_pick(input logic if_req, input logic dm_req,
                                      input logic tie_gnt);
        logic pick;
        if (if_req && dm_req)
            pick = tie_gnt;
        else if (dm_req)
            pick = PORT_DM;
        else
            pick = PORT_IF;
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux32.sv
// 32-bit 2:1 mux: control = 0 selects in1, control = 1 selects in2.
module Mux32 (
    input  logic        control,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] mux_out
);

    assign mux_out = control ? in2 : in1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory requesters.
// Tie-break policy: fixed DM priority by default, round robin when ARB_ROUND_ROBIN_EN is defined.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// ISSUE | mem_en strobe, latency counter loaded
// WAIT  | counting down the memory latency
// CAPT  | mem_rdata valid; capture into granted port, raise its ack
// DONE  | ack visible to the granted port; requests ignored
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_sel,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             gnt;
    logic             wr_q;
    logic             tie_gnt;
    logic             pick;
    logic             any_req;
    logic [AW-1:0]    mux_addr;

    assign any_req = if_req | dm_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= PORT_IF;
        else if (state == IDLE && any_req)
            last_gnt <= pick;
    end

    assign tie_gnt = ~last_gnt;
`else
    // The MEM-stage instruction is older than the one being fetched.
    assign tie_gnt = PORT_DM;
`endif

    assign pick = arb_pick(if_req, dm_req, tie_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = (MEM_LAT == 1) ? CAPT : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = CAPT;
            CAPT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            gnt      <= PORT_IF;
            wr_q     <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt  <= pick;
                        wr_q <= (pick == PORT_DM) && dm_we;
                    end
                end
                ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
                WAIT:  cnt <= cnt - CNT_W'(1);
                CAPT: begin
                    // Write type is latched at grant so a misbehaving requester cannot corrupt dm_rdata.
                    if (gnt == PORT_DM) begin
                        dm_ack <= 1'b1;
                        if (!wr_q)
                            dm_rdata <= mem_rdata;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    Mux32 u_addr_mux (
        .control (gnt),
        .in1     (if_addr),
        .in2     (dm_addr),
        .mux_out (mux_addr)
    );

    assign busy      = (state != IDLE);
    assign mem_sel   = gnt;
    assign mem_en    = (state == ISSUE);
    assign mem_we    = dm_we & mem_sel & mem_en;
    assign mem_addr  = busy ? mux_addr : '0;
    assign mem_wdata = (busy && gnt) ? dm_wdata : '0;

endmodule
